// File: rtl/vs0_copier_pkg.sv
// Shared types and constants for the VS0 Wishbone block copier.
package vs0_copier_pkg;

   localparam int unsigned ADR_W = 28;
   localparam int unsigned DAT_W = 32;
   localparam logic [3:0] SEL_ALL = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } state_t;

endpackage

// File: rtl/vs0_copier_buf.sv
// Chunk buffer: BUF_DEPTH x 32 registers, one synchronous write port, asynchronous read.
// VS0_COPIER_CHECKSUM_EN adds a second asynchronous read port for the checksum adder.
module vs0_copier_buf
   import vs0_copier_pkg::*;
#(
   parameter int unsigned BUF_DEPTH = 8
) (
   input  logic                         sys_clk,
   input  logic                         wr_en,
   input  logic [$clog2(BUF_DEPTH)-1:0] wr_idx,
   input  logic [DAT_W-1:0]             wr_dat,
   input  logic [$clog2(BUF_DEPTH)-1:0] rd_idx,
   output logic [DAT_W-1:0]             rd_dat
`ifdef VS0_COPIER_CHECKSUM_EN
   ,
   input  logic [$clog2(BUF_DEPTH)-1:0] rd2_idx,
   output logic [DAT_W-1:0]             rd2_dat
`endif
);

   logic [DAT_W-1:0] mem [BUF_DEPTH];

   always_ff @(posedge sys_clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_dat;
      end
   end

   assign rd_dat = mem[rd_idx];

`ifdef VS0_COPIER_CHECKSUM_EN
   assign rd2_dat = mem[rd2_idx];
`endif

endmodule

// File: rtl/vs0_wbm_copier.sv
// Pipelined Wishbone initiator copying word blocks in chunks of up to BUF_DEPTH words.
// Optional VS0_COPIER_CHECKSUM_EN adds a checksum output summing every acknowledged write.
module vs0_wbm_copier
   import vs0_copier_pkg::*;
#(
   parameter int unsigned BUF_DEPTH = 8,
   parameter int unsigned LEN_W     = 16
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADR_W-1:0]  cmd_src_adr,
   input  logic [ADR_W-1:0]  cmd_dst_adr,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              busy,
   output logic              done,
   output logic              done_err,
   output logic [ADR_W-1:0]  wbm_adr_o,
   output logic [DAT_W-1:0]  wbm_dat_o,
   input  logic [DAT_W-1:0]  wbm_dat_i,
   output logic              wbm_we_o,
   output logic [3:0]        wbm_sel_o,
   output logic              wbm_stb_o,
   output logic              wbm_cyc_o,
   input  logic              wbm_ack_i,
   input  logic              wbm_stall_i,
   input  logic              wbm_err_i
`ifdef VS0_COPIER_CHECKSUM_EN
   ,
   output logic [DAT_W-1:0]  checksum
`endif
);

   localparam int unsigned IDX_W = $clog2(BUF_DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;

   function automatic logic [CNT_W-1:0] chunk_of(input logic [LEN_W-1:0] rem);
      if (rem >= LEN_W'(BUF_DEPTH)) begin
         return CNT_W'(BUF_DEPTH);
      end
      return CNT_W'(rem);
   endfunction

   state_t           state, state_nx;
   logic [ADR_W-1:0] src_adr, dst_adr;
   logic [LEN_W-1:0] remaining, rem_left;
   logic [CNT_W-1:0] chunk, issued, acked;
   logic             gap, err_flag;
   logic             accept, active, stb, issue, ack_ok, last, err_hit;
   logic [DAT_W-1:0] buf_rd;

   always_comb begin
      state_nx = state;
      accept   = (state == IDLE) && cmd_valid;
      active   = ((state == READ) || (state == WRITE)) && !gap;
      stb      = active && (issued < chunk);
      issue    = stb && !wbm_stall_i;
      err_hit  = active && wbm_err_i;
      // An ack counts only against an outstanding or same-cycle request.
      ack_ok   = active && wbm_ack_i && !wbm_err_i && ((acked < issued) || issue);
      last     = ack_ok && (acked == (chunk - CNT_W'(1)));
      rem_left = remaining - LEN_W'(chunk);
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nx = (cmd_len == '0) ? DONE : READ;
            end
         end
         READ: begin
            if (err_hit) begin
               state_nx = DONE;
            end else if (last) begin
               state_nx = WRITE;
            end
         end
         WRITE: begin
            if (err_hit) begin
               state_nx = DONE;
            end else if (last) begin
               state_nx = (rem_left == '0) ? DONE : READ;
            end
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         src_adr   <= '0;
         dst_adr   <= '0;
         remaining <= '0;
         chunk     <= '0;
         issued    <= '0;
         acked     <= '0;
         gap       <= 1'b0;
         err_flag  <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            src_adr   <= cmd_src_adr;
            dst_adr   <= cmd_dst_adr;
            remaining <= cmd_len;
            chunk     <= chunk_of(cmd_len);
            issued    <= '0;
            acked     <= '0;
            gap       <= 1'b0;
            err_flag  <= 1'b0;
         end else begin
            gap <= 1'b0;
            if (issue) begin
               issued <= issued + CNT_W'(1);
               if (state == WRITE) begin
                  dst_adr <= dst_adr + ADR_W'(1);
               end else begin
                  src_adr <= src_adr + ADR_W'(1);
               end
            end
            if (ack_ok) begin
               acked <= acked + CNT_W'(1);
            end
            if (err_hit) begin
               err_flag <= 1'b1;
            end
            // Chunk boundary: rewind counters, insert the idle cycle unless finishing.
            if (last) begin
               issued <= '0;
               acked  <= '0;
               gap    <= (state == READ) || (rem_left != '0);
               if (state == WRITE) begin
                  remaining <= rem_left;
                  chunk     <= chunk_of(rem_left);
               end
            end
         end
      end
   end

`ifdef VS0_COPIER_CHECKSUM_EN
   logic [DAT_W-1:0] csum_rd;

   vs0_copier_buf #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
      .sys_clk (sys_clk),
      .wr_en   ((state == READ) && ack_ok),
      .wr_idx  (acked[IDX_W-1:0]),
      .wr_dat  (wbm_dat_i),
      .rd_idx  (issued[IDX_W-1:0]),
      .rd_dat  (buf_rd),
      .rd2_idx (acked[IDX_W-1:0]),
      .rd2_dat (csum_rd)
   );

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
      end else if (accept) begin
         checksum <= '0;
      end else if ((state == WRITE) && ack_ok) begin
         checksum <= checksum + csum_rd;
      end
   end
`else
   vs0_copier_buf #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
      .sys_clk (sys_clk),
      .wr_en   ((state == READ) && ack_ok),
      .wr_idx  (acked[IDX_W-1:0]),
      .wr_dat  (wbm_dat_i),
      .rd_idx  (issued[IDX_W-1:0]),
      .rd_dat  (buf_rd)
   );
`endif

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign done_err  = (state == DONE) && err_flag;
   assign wbm_cyc_o = active;
   assign wbm_stb_o = stb;
   assign wbm_we_o  = active && (state == WRITE);
   assign wbm_sel_o = stb ? SEL_ALL : '0;
   assign wbm_adr_o = !active ? '0 : ((state == WRITE) ? dst_adr : src_adr);
   assign wbm_dat_o = (stb && (state == WRITE)) ? buf_rd : '0;

endmodule

// File: tb/tb_vs0_wbm_copier.sv
// Directed self-checking bench for vs0_wbm_copier with a pipelined Wishbone memory slave model.
`timescale 1ns/1ps
module tb_vs0_wbm_copier;

   logic        sys_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [27:0] cmd_src_adr = '0;
   logic [27:0] cmd_dst_adr = '0;
   logic [15:0] cmd_len = '0;
   logic        busy, done, done_err;
   logic [27:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i = '0;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic        wbm_stb_o, wbm_cyc_o;
   logic        wbm_ack_i = 1'b0;
   logic        wbm_stall_i = 1'b0;
   logic        wbm_err_i = 1'b0;
`ifdef VS0_COPIER_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   vs0_wbm_copier #(.BUF_DEPTH(8), .LEN_W(16)) dut (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_src_adr (cmd_src_adr),
      .cmd_dst_adr (cmd_dst_adr),
      .cmd_len     (cmd_len),
      .busy        (busy),
      .done        (done),
      .done_err    (done_err),
      .wbm_adr_o   (wbm_adr_o),
      .wbm_dat_o   (wbm_dat_o),
      .wbm_dat_i   (wbm_dat_i),
      .wbm_we_o    (wbm_we_o),
      .wbm_sel_o   (wbm_sel_o),
      .wbm_stb_o   (wbm_stb_o),
      .wbm_cyc_o   (wbm_cyc_o),
      .wbm_ack_i   (wbm_ack_i),
      .wbm_stall_i (wbm_stall_i),
      .wbm_err_i   (wbm_err_i)
`ifdef VS0_COPIER_CHECKSUM_EN
      ,
      .checksum    (checksum)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   int errors = 0;
   int checks = 0;
   int cyc_n  = 0;
   always @(posedge sys_clk) cyc_n++;

   typedef struct {
      logic [27:0] adr;
      logic        we;
      logic [31:0] dat;
      int          rdy;
   } req_t;

   logic [31:0] mem [logic [27:0]];
   req_t        q [$];
   logic [27:0] rd_log [$];
   logic [27:0] wr_adr_log [$];
   logic [31:0] wr_dat_log [$];

   bit stall_mode = 0;
   int max_delay  = 0;
   int err_at     = 0;
   int last_rdy   = -1;
   int rd_ack_cnt, wr_issue_cnt, done_cnt, done_cyc, last_wr_ack_cyc;
   int err_cyc, cyc_after_err, falls, low_cnt, stall_viol, cyc_seen_cnt;
   bit seen_cyc, last_done_err, prev_cyc, prev_hold, prev_we;
   logic [27:0] prev_adr;
   logic [31:0] prev_dat;
   req_t r_new, r_head;

   function automatic logic [31:0] rd_mem(input logic [27:0] a);
      return mem.exists(a) ? mem[a] : 32'hBAD0_0000;
   endfunction

   // Slave and monitor: decide stall/ack for the current cycle on the falling edge.
   always @(negedge sys_clk) begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_dat_i = '0;
      if (done) begin
         done_cnt++;
         done_cyc = cyc_n;
         last_done_err = done_err;
      end
      if (!rst_n) begin
         q.delete();
         prev_hold = 0;
         prev_cyc = 0;
         wbm_stall_i = 1'b0;
      end else begin
         if (prev_hold && (wbm_stb_o !== 1'b1 || wbm_adr_o !== prev_adr ||
                           wbm_dat_o !== prev_dat || wbm_we_o !== prev_we))
            stall_viol++;
         if (busy && !done) begin
            if (wbm_cyc_o) seen_cyc = 1;
            else if (seen_cyc) low_cnt++;
         end
         if (prev_cyc && !wbm_cyc_o) falls++;
         if (wbm_cyc_o) cyc_seen_cnt++;
         if (err_cyc >= 0 && cyc_n == err_cyc + 1) cyc_after_err = int'(wbm_cyc_o);
         prev_cyc = wbm_cyc_o;

         wbm_stall_i = stall_mode ? 1'($urandom_range(0, 1)) : 1'b0;
         if (wbm_cyc_o && wbm_stb_o && !wbm_stall_i) begin
            r_new.adr = wbm_adr_o;
            r_new.we  = wbm_we_o;
            r_new.dat = wbm_dat_o;
            r_new.rdy = cyc_n + ((max_delay > 0) ? int'($urandom_range(0, max_delay)) : 0);
            if (r_new.rdy <= last_rdy) r_new.rdy = last_rdy + 1;
            last_rdy = r_new.rdy;
            q.push_back(r_new);
            if (wbm_we_o) wr_issue_cnt++;
            else rd_log.push_back(wbm_adr_o);
         end
         if (q.size() > 0 && q[0].rdy <= cyc_n) begin
            r_head = q.pop_front();
            if (!r_head.we) begin
               rd_ack_cnt++;
               if (rd_ack_cnt == err_at) begin
                  wbm_err_i = 1'b1;
                  q.delete();
                  err_cyc = cyc_n;
               end else begin
                  wbm_ack_i = 1'b1;
                  wbm_dat_i = rd_mem(r_head.adr);
               end
            end else begin
               wbm_ack_i = 1'b1;
               mem[r_head.adr] = r_head.dat;
               wr_adr_log.push_back(r_head.adr);
               wr_dat_log.push_back(r_head.dat);
               last_wr_ack_cyc = cyc_n;
            end
         end
         prev_hold = wbm_stb_o && wbm_stall_i;
         prev_adr  = wbm_adr_o;
         prev_dat  = wbm_dat_o;
         prev_we   = wbm_we_o;
      end
   end

   task automatic clear_stats();
      rd_log.delete();
      wr_adr_log.delete();
      wr_dat_log.delete();
      rd_ack_cnt = 0; wr_issue_cnt = 0; done_cnt = 0; done_cyc = -1;
      last_wr_ack_cyc = -1; err_cyc = -1; cyc_after_err = -1;
      falls = 0; low_cnt = 0; stall_viol = 0; cyc_seen_cnt = 0;
      seen_cyc = 0; last_done_err = 0;
   endtask

   task automatic preload(input logic [27:0] base, input int n, input logic [31:0] seed);
      for (int i = 0; i < n; i++) mem[base + 28'(i)] = seed + 32'(i);
   endtask

   task automatic run_cmd(input logic [27:0] src, input logic [27:0] dst,
                          input logic [15:0] len, output int acc_cyc);
      clear_stats();
      @(negedge sys_clk);
      cmd_src_adr = src;
      cmd_dst_adr = dst;
      cmd_len     = len;
      cmd_valid   = 1'b1;
      acc_cyc     = cyc_n;
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
         @(posedge sys_clk);
         #1;
      end
      if (done_cnt == 0) begin
         checks++; errors++;
         $display("FAIL done_timeout: done_cnt=%0d required>=1", done_cnt);
      end
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      checks++;
      if ({busy, done, done_err, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 000000",
                  {busy, done, done_err, wbm_cyc_o, wbm_stb_o, wbm_we_o});
      end
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
      checks++;
      if (wbm_sel_o !== 4'h0) begin errors++; $display("FAIL reset_sel: got %h required 0", wbm_sel_o); end
      checks++;
      if (wbm_adr_o !== 28'h0) begin errors++; $display("FAIL reset_adr: got %h required 0", wbm_adr_o); end
      checks++;
      if (wbm_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h required 0", wbm_dat_o); end
      rst_n = 1'b1;
      @(negedge sys_clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle: ready=%b busy=%b required 1 0", cmd_ready, busy);
      end
   endtask

   task automatic test_basic();
      int acc;
      preload(28'h100, 3, 32'h1111_0000);
      run_cmd(28'h100, 28'h200, 16'd3, acc);
      checks++;
      if (rd_log.size() !== 3) begin errors++; $display("FAIL basic_nreads: got %0d required 3", rd_log.size()); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (((i < rd_log.size()) ? rd_log[i] : 28'hx) !== 28'h100 + 28'(i)) begin
            errors++; $display("FAIL basic_rd_adr[%0d]: required %h", i, 28'h100 + 28'(i));
         end
         checks++;
         if (((i < wr_adr_log.size()) ? wr_adr_log[i] : 28'hx) !== 28'h200 + 28'(i)) begin
            errors++; $display("FAIL basic_wr_adr[%0d]: required %h", i, 28'h200 + 28'(i));
         end
         checks++;
         if (((i < wr_dat_log.size()) ? wr_dat_log[i] : 32'hx) !== 32'h1111_0000 + 32'(i)) begin
            errors++; $display("FAIL basic_wr_dat[%0d]: required %h", i, 32'h1111_0000 + 32'(i));
         end
      end
      checks++;
      if (done_cnt !== 1 || last_done_err !== 1'b0) begin
         errors++; $display("FAIL basic_done: cnt=%0d err=%b required 1 0", done_cnt, last_done_err);
      end
   endtask

   task automatic test_chunks();
      int acc;
      preload(28'h1000, 20, 32'h2000_0000);
      run_cmd(28'h1000, 28'h2000, 16'd20, acc);
      checks++;
      if (wr_adr_log.size() !== 20) begin errors++; $display("FAIL chunk_nwrites: got %0d required 20", wr_adr_log.size()); end
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (rd_mem(28'h2000 + 28'(i)) !== 32'h2000_0000 + 32'(i)) begin
            errors++; $display("FAIL chunk_data[%0d]: got %h required %h", i,
                               rd_mem(28'h2000 + 28'(i)), 32'h2000_0000 + 32'(i));
         end
      end
      checks++;
      if (low_cnt !== 5) begin errors++; $display("FAIL chunk_gaps: got %0d required 5", low_cnt); end
      checks++;
      if (falls !== 6) begin errors++; $display("FAIL chunk_phases: got %0d required 6", falls); end
      checks++;
      if (done_cyc !== last_wr_ack_cyc + 1) begin
         errors++; $display("FAIL chunk_done_time: got %0d required %0d", done_cyc, last_wr_ack_cyc + 1);
      end
      checks++;
      if (done_cnt !== 1) begin errors++; $display("FAIL chunk_done_cnt: got %0d required 1", done_cnt); end
   endtask

   task automatic test_stall();
      int acc;
      preload(28'h300, 9, 32'h3C00_0000);
      stall_mode = 1; max_delay = 3;
      run_cmd(28'h300, 28'h400, 16'd9, acc);
      stall_mode = 0; max_delay = 0;
      checks++;
      if (stall_viol !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes required 0", stall_viol); end
      checks++;
      if (wr_adr_log.size() !== 9) begin errors++; $display("FAIL stall_nwrites: got %0d required 9", wr_adr_log.size()); end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (rd_mem(28'h400 + 28'(i)) !== 32'h3C00_0000 + 32'(i)) begin
            errors++; $display("FAIL stall_data[%0d]: got %h required %h", i,
                               rd_mem(28'h400 + 28'(i)), 32'h3C00_0000 + 32'(i));
         end
      end
   endtask

   task automatic test_err();
      int acc;
      preload(28'h500, 5, 32'h5000_0000);
      err_at = 2;
      run_cmd(28'h500, 28'h600, 16'd5, acc);
      err_at = 0;
      checks++;
      if (cyc_after_err !== 0) begin errors++; $display("FAIL err_cyc_drop: got %0d required 0", cyc_after_err); end
      checks++;
      if (wr_issue_cnt !== 0) begin errors++; $display("FAIL err_writes: got %0d required 0", wr_issue_cnt); end
      checks++;
      if (done_cnt !== 1 || last_done_err !== 1'b1) begin
         errors++; $display("FAIL err_done: cnt=%0d err=%b required 1 1", done_cnt, last_done_err);
      end
   endtask

   task automatic test_len0();
      int acc;
      run_cmd(28'h800, 28'h900, 16'd0, acc);
      checks++;
      if (done_cyc !== acc + 1) begin errors++; $display("FAIL len0_done_time: got %0d required %0d", done_cyc, acc + 1); end
      checks++;
      if (cyc_seen_cnt !== 0) begin errors++; $display("FAIL len0_no_bus: got %0d cyc cycles required 0", cyc_seen_cnt); end
      checks++;
      if (done_cnt !== 1 || last_done_err !== 1'b0) begin
         errors++; $display("FAIL len0_done: cnt=%0d err=%b required 1 0", done_cnt, last_done_err);
      end
   endtask

   task automatic test_wrap();
      int acc;
      logic [27:0] exp_adr [4];
      exp_adr = '{28'hFFFFFFE, 28'hFFFFFFF, 28'h0000000, 28'h0000001};
      preload(28'hFFFFFFE, 4, 32'h7700_0000);
      run_cmd(28'hFFFFFFE, 28'h700, 16'd4, acc);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (((i < rd_log.size()) ? rd_log[i] : 28'hx) !== exp_adr[i]) begin
            errors++; $display("FAIL wrap_rd_adr[%0d]: required %h", i, exp_adr[i]);
         end
      end
      checks++;
      if (rd_mem(28'h703) !== 32'h7700_0003) begin
         errors++; $display("FAIL wrap_data: got %h required 77000003", rd_mem(28'h703));
      end
   endtask

`ifdef VS0_COPIER_CHECKSUM_EN
   task automatic test_checksum();
      int acc;
      mem[28'hA00] = 32'd1; mem[28'hA01] = 32'd2; mem[28'hA02] = 32'd3;
      run_cmd(28'hA00, 28'hB00, 16'd3, acc);
      checks++;
      if (checksum !== 32'd6) begin errors++; $display("FAIL checksum: got %0d required 6", checksum); end
   endtask
`endif

   task automatic test_reset_mid();
      int acc;
      preload(28'hC00, 20, 32'hC000_0000);
      clear_stats();
      @(negedge sys_clk);
      cmd_src_adr = 28'hC00; cmd_dst_adr = 28'hD00; cmd_len = 16'd20; cmd_valid = 1'b1;
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 200 && wbm_we_o !== 1'b1; i++) @(negedge sys_clk);
      checks++;
      if (wbm_we_o !== 1'b1) begin errors++; $display("FAIL midrst_reach_write: we=%b required 1", wbm_we_o); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
         errors++; $display("FAIL midrst_cyc: cyc=%b stb=%b required 0 0", wbm_cyc_o, wbm_stb_o);
      end
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b required 1", cmd_ready); end
      repeat (3) @(negedge sys_clk);
      rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      checks++;
      if (done_cnt !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d required 0", done_cnt); end
      preload(28'hE00, 2, 32'hE000_0000);
      run_cmd(28'hE00, 28'hF00, 16'd2, acc);
      checks++;
      if (rd_mem(28'hF01) !== 32'hE000_0001 || done_cnt !== 1) begin
         errors++; $display("FAIL midrst_recover: data=%h done=%0d required e0000001 1", rd_mem(28'hF01), done_cnt);
      end
   endtask

   initial begin
      clear_stats();
      test_reset();
      test_basic();
      test_chunks();
      test_stall();
      test_err();
      test_len0();
      test_wrap();
`ifdef VS0_COPIER_CHECKSUM_EN
      test_checksum();
`endif
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
